// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame length and default timing.
// Used by both the host transmitter and the device-to-host receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int unsigned FRAME_BITS         = 11;
    localparam int unsigned DEF_INHIBIT_CYCLES = 12000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2000000;

    // {stop, odd parity, data LSB-first, start}
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge strobe on clock.
// Registers reset to 1 so an idle bus does not produce a spurious edge after reset.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic sync_clk,
    output logic sync_data,
    output logic clk_fall
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            data_meta <= 1'b1;
            sync_clk  <= 1'b1;
            sync_data <= 1'b1;
            clk_prev  <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            data_meta <= ps2_data_in;
            sync_clk  <= clk_meta;
            sync_data <= data_meta;
            clk_prev  <= sync_clk;
        end
    end

    assign clk_fall = clk_prev & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte on device clock falls,
// collect the ACK bit and wait for the bus to go idle. Open-drain outputs: *_oe = 1 pulls the pad low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       STOP_IDX = 4'(FRAME_BITS - 1);

    ps2_state_t            state;
    logic [FRAME_BITS-1:0] frame;
    logic [3:0]            idx;
    logic [INH_W-1:0]      inh_cnt;
    logic [WD_W-1:0]       wd_cnt;
    logic                  nack;
    logic                  wd_active;

    logic sync_clk;
    logic sync_data;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .sync_clk    (sync_clk),
        .sync_data   (sync_data),
        .clk_fall    (clk_fall)
    );

    always_comb begin
        wd_active = 1'b0;
        if (state == RTS || state == SHIFT || state == ACK || state == WAIT_IDLE)
            wd_active = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frame       <= '0;
            idx         <= '0;
            inh_cnt     <= '0;
            wd_cnt      <= '0;
            nack        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
            // Watchdog expiry wins over any fall seen in the same cycle.
            if (wd_active && wd_cnt == WD_LAST) begin
                state       <= IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                busy        <= 1'b0;
                tx_ready    <= 1'b1;
                timeout     <= 1'b1;
            end else begin
                if (wd_active)
                    wd_cnt <= wd_cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            frame       <= build_frame(tx_data);
                            inh_cnt     <= '0;
                            nack        <= 1'b0;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            busy        <= 1'b1;
                            tx_ready    <= 1'b0;
                            state       <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt == INH_LAST) begin
                            ps2_data_oe <= 1'b1;
                            wd_cnt      <= '0;
                            state       <= RTS;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    RTS: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= ~frame[0];
                        idx         <= '0;
                        state       <= SHIFT;
                    end
                    SHIFT: begin
                        if (clk_fall) begin
                            if (idx == STOP_IDX) begin
                                nack  <= sync_data;
                                state <= ACK;
                            end else begin
                                idx         <= idx + 4'd1;
                                ps2_data_oe <= ~frame[idx + 4'd1];
                            end
                        end
                    end
                    ACK: begin
                        ps2_data_oe <= 1'b0;
                        state       <= WAIT_IDLE;
                    end
                    WAIT_IDLE: begin
                        if (sync_clk && sync_data) begin
                            done     <= 1'b1;
                            ack_err  <= nack;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
